// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory-bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY)
//   ERR_RDATA   : read data returned to a master whose transfer was aborted by timeout
//   GNT_*       : one-hot grant encodings {m1,m0}
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/mem_arb_timer.sv
// Transaction watchdog for the memory-bus arbiter.
// Counts cycles while enable is high; clear has priority and zeroes the count.
// expire is high while the count equals TIMEOUT-1.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the counter
//   enable    : count this cycle
//   expire    : count has reached TIMEOUT-1
module mem_arb_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of one picorv32-style native memory-bus slave.
// One whole transaction is granted at a time; at least one IDLE cycle separates
// transactions. Winner selection is round-robin (RR=1) or fixed m0 priority (RR=0).
// Optional feature macro: MEM_ARB_TIMEOUT_EN -- when defined, a transfer stuck in
// BUSY for TIMEOUT cycles is completed with ERR_RDATA and a one-cycle err pulse.
//
// Handshake: a master raises mX_valid and holds it with stable addr/wdata/wstrb
// until mX_ready; mX_ready is a single-cycle completion with mX_rdata valid in the
// same cycle. The slave side follows the same rule with s_valid/s_ready.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   m0_* / m1_*                  : master request (valid/addr/wdata/wstrb) and response (ready/rdata)
//   s_valid/s_addr/s_wdata/s_wstrb : request to slave, from the granted master
//   s_ready/s_rdata              : slave completion
//   gnt                          : one-hot grant {m1,m0}, 0 when idle
//   err                          : one-cycle pulse on timeout abort
//   state_dbg                    : 1 while the FSM is in BUSY
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RR      = 1,
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  gnt,
  output logic        err,
  output logic        state_dbg
);

  arb_state_t  state, state_nxt;
  logic [1:0]  gnt_q, gnt_nxt;
  logic        last_m1, last_nxt;   // 1 = m1 finished the most recent transaction
  logic        g_valid;
  logic        expire;
  logic        done;                // granted master gets ready this cycle
  logic [31:0] done_rdata;

  assign g_valid = (gnt_q[0] & m0_valid) | (gnt_q[1] & m1_valid);

`ifdef MEM_ARB_TIMEOUT_EN
  logic timer_expire;

  // Held clear throughout IDLE, so the count is 0 in the first BUSY cycle.
  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .enable (state == BUSY),
    .expire (timer_expire)
  );

  assign expire = (state == BUSY) & timer_expire;
`else
  // TIMEOUT has no effect in this build; BUSY waits for the slave indefinitely.
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT);
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt_q   <= GNT_NONE;
      last_m1 <= 1'b1;
    end else begin
      state   <= state_nxt;
      gnt_q   <= gnt_nxt;
      last_m1 <= last_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt_q;
    last_nxt   = last_m1;
    s_valid    = 1'b0;
    done       = 1'b0;
    done_rdata = 32'h0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          gnt_nxt   = ((RR != 0) && !last_m1) ? GNT_M1 : GNT_M0;
          state_nxt = BUSY;
        end else if (m0_valid) begin
          gnt_nxt   = GNT_M0;
          state_nxt = BUSY;
        end else if (m1_valid) begin
          gnt_nxt   = GNT_M1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!g_valid) begin
          // Master withdrew its request: drop it silently, fairness state untouched.
          gnt_nxt   = GNT_NONE;
          state_nxt = IDLE;
        end else if (s_ready) begin
          // Completion beats a coincident timeout.
          s_valid    = 1'b1;
          done       = 1'b1;
          done_rdata = s_rdata;
          last_nxt   = gnt_q[1];
          gnt_nxt    = GNT_NONE;
          state_nxt  = IDLE;
        end else if (expire) begin
          done       = 1'b1;
          done_rdata = ERR_RDATA;
          err        = 1'b1;
          last_nxt   = gnt_q[1];
          gnt_nxt    = GNT_NONE;
          state_nxt  = IDLE;
        end else begin
          s_valid = 1'b1;
        end
      end
      default: begin
        gnt_nxt   = GNT_NONE;
        state_nxt = IDLE;
      end
    endcase
  end

  assign m0_ready = done & gnt_q[0];
  assign m1_ready = done & gnt_q[1];
  assign m0_rdata = m0_ready ? done_rdata : 32'h0;
  assign m1_rdata = m1_ready ? done_rdata : 32'h0;

  assign s_addr  = gnt_q[1] ? m1_addr  : m0_addr;
  assign s_wdata = gnt_q[1] ? m1_wdata : m0_wdata;
  assign s_wstrb = gnt_q[1] ? m1_wstrb : m0_wstrb;

  assign gnt       = gnt_q;
  assign state_dbg = (state == BUSY);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter. Two instances share every input: index 0 is
// round-robin (RR=1), index 1 is fixed priority (RR=0).
module tb_mem_bus_arbiter;

  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m0_valid, m1_valid, s_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  logic        d_m0_ready[2], d_m1_ready[2], d_s_valid[2], d_err[2], d_state[2];
  logic [31:0] d_m0_rdata[2], d_m1_rdata[2], d_s_addr[2], d_s_wdata[2];
  logic [3:0]  d_s_wstrb[2];
  logic [1:0]  d_gnt[2];

  mem_bus_arbiter #(.RR(1), .TIMEOUT(TMO)) u_rr (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(d_m0_ready[0]), .m0_rdata(d_m0_rdata[0]),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(d_m1_ready[0]), .m1_rdata(d_m1_rdata[0]),
    .s_valid(d_s_valid[0]), .s_addr(d_s_addr[0]), .s_wdata(d_s_wdata[0]), .s_wstrb(d_s_wstrb[0]),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .gnt(d_gnt[0]), .err(d_err[0]), .state_dbg(d_state[0])
  );

  mem_bus_arbiter #(.RR(0), .TIMEOUT(TMO)) u_fp (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(d_m0_ready[1]), .m0_rdata(d_m0_rdata[1]),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(d_m1_ready[1]), .m1_rdata(d_m1_rdata[1]),
    .s_valid(d_s_valid[1]), .s_addr(d_s_addr[1]), .s_wdata(d_s_wdata[1]), .s_wstrb(d_s_wstrb[1]),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .gnt(d_gnt[1]), .err(d_err[1]), .state_dbg(d_state[1])
  );

  // ---------------- vectors / scoreboard ----------------
  typedef struct {
    logic        m0_v;
    logic        m1_v;
    logic [31:0] m0_addr;
    logic [31:0] m1_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic [3:0]  m0_wstrb;
    logic [3:0]  m1_wstrb;
    int          lat;
    logic [31:0] rdata;
    logic [1:0]  exp_rr;
    logic [1:0]  exp_fp;
  } vec_t;

  vec_t        vecs[8];
  logic [33:0] exp_q[$];   // {expected grant, expected rdata}
  int          n_vec = 0;
  int          n_err = 0;

  function automatic vec_t mk(logic m0v, logic m1v, logic [3:0] ws0, logic [3:0] ws1,
                              int lat, logic [31:0] rdata, logic [1:0] rr, logic [1:0] fp);
    vec_t v;
    v.m0_v = m0v;               v.m1_v = m1v;
    v.m0_addr = $urandom;       v.m1_addr = $urandom;
    v.m0_wdata = $urandom;      v.m1_wdata = $urandom;
    v.m0_wstrb = ws0;           v.m1_wstrb = ws1;
    v.lat = lat;                v.rdata = rdata;
    v.exp_rr = rr;              v.exp_fp = fp;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_vec(vec_t v);
    m0_valid = v.m0_v;  m0_addr = v.m0_addr;  m0_wdata = v.m0_wdata;  m0_wstrb = v.m0_wstrb;
    m1_valid = v.m1_v;  m1_addr = v.m1_addr;  m1_wdata = v.m1_wdata;  m1_wstrb = v.m1_wstrb;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one transaction at a negedge with the DUTs idle, returns at the
  // negedge of the idle cycle that follows completion.
  task automatic run_txn(vec_t v);
    logic [1:0]  g;
    logic [33:0] e;
    drive_vec(v);
    exp_q.push_back({v.exp_rr, v.rdata});
    exp_q.push_back({v.exp_fp, v.rdata});
    cycle();
    for (int k = 0; k < 2; k++) begin
      g = (k == 0) ? v.exp_rr : v.exp_fp;
      check($sformatf("gnt[%0d]", k), 32'(d_gnt[k]), 32'(g));
      check($sformatf("s_valid[%0d]", k), 32'(d_s_valid[k]), 32'd1);
      check($sformatf("s_addr[%0d]", k), d_s_addr[k], g[1] ? v.m1_addr : v.m0_addr);
      check($sformatf("s_wdata[%0d]", k), d_s_wdata[k], g[1] ? v.m1_wdata : v.m0_wdata);
      check($sformatf("s_wstrb[%0d]", k), 32'(d_s_wstrb[k]), 32'(g[1] ? v.m1_wstrb : v.m0_wstrb));
    end
    repeat (v.lat) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("wait_ready[%0d]", k), 32'({d_m1_ready[k], d_m0_ready[k]}), 32'd0);
        check($sformatf("wait_err[%0d]", k), 32'(d_err[k]), 32'd0);
      end
      cycle();
    end
    s_ready = 1'b1;
    s_rdata = v.rdata;
    #1;
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      g = e[33:32];
      check($sformatf("m0_ready[%0d]", k), 32'(d_m0_ready[k]), 32'(g[0]));
      check($sformatf("m1_ready[%0d]", k), 32'(d_m1_ready[k]), 32'(g[1]));
      check($sformatf("m0_rdata[%0d]", k), d_m0_rdata[k], g[0] ? e[31:0] : 32'h0);
      check($sformatf("m1_rdata[%0d]", k), d_m1_rdata[k], g[1] ? e[31:0] : 32'h0);
      check($sformatf("done_err[%0d]", k), 32'(d_err[k]), 32'd0);
    end
    cycle();
    s_ready = 1'b0;
    s_rdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("idle_gnt[%0d]", k), 32'(d_gnt[k]), 32'd0);
      check($sformatf("idle_s_valid[%0d]", k), 32'(d_s_valid[k]), 32'd0);
    end
  endtask

  task automatic check_quiet(string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_gnt[%0d]", tag, k), 32'(d_gnt[k]), 32'd0);
      check($sformatf("%s_s_valid[%0d]", tag, k), 32'(d_s_valid[k]), 32'd0);
      check($sformatf("%s_ready[%0d]", tag, k), 32'({d_m1_ready[k], d_m0_ready[k]}), 32'd0);
      check($sformatf("%s_err[%0d]", tag, k), 32'(d_err[k]), 32'd0);
      check($sformatf("%s_state[%0d]", tag, k), 32'(d_state[k]), 32'd0);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    rst = 1'b1;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 1'b0;  s_rdata = '0;

    // Both valid continuously: RR alternates m0,m1,m0,m1; fixed priority stays on m0.
    vecs[0] = mk(1, 1, 4'h0, 4'h0, 0, $urandom, 2'b01, 2'b01);
    vecs[1] = mk(1, 1, 4'hf, 4'h0, 2, $urandom, 2'b10, 2'b01);
    vecs[2] = mk(1, 1, 4'h0, 4'h3, 1, $urandom, 2'b01, 2'b01);
    vecs[3] = mk(1, 1, 4'h0, 4'h0, 0, $urandom, 2'b10, 2'b01);
    // m0 dropped: m1 write reaches the slave on both arbiters.
    vecs[4] = mk(0, 1, 4'h0, 4'b0011, 1, $urandom, 2'b10, 2'b10);
    vecs[4].m1_wdata = 32'hA5A5_0000;
    // m0 read, slave ready after 3 wait cycles.
    vecs[5] = mk(1, 0, 4'h0, 4'h0, 3, 32'h1234_5678, 2'b01, 2'b01);
    vecs[5].m0_addr = 32'h5000_0000;
    vecs[6] = mk(1, 1, 4'h1, 4'h8, 2, $urandom, 2'b10, 2'b01);
    vecs[7] = mk(1, 0, 4'hc, 4'h0, 0, $urandom, 2'b01, 2'b01);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    cycle();
    check_quiet("post_reset");

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i]);
    end

    // Abort: m1 withdraws while granted; RR fairness state (last = m0) must not move.
    v = mk(0, 1, 4'h0, 4'h0, 0, $urandom, 2'b10, 2'b10);
    drive_vec(v);
    cycle();
    for (int k = 0; k < 2; k++) check($sformatf("abort_gnt[%0d]", k), 32'(d_gnt[k]), 32'd2);
    m1_valid = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("abort_s_valid[%0d]", k), 32'(d_s_valid[k]), 32'd0);
      check($sformatf("abort_ready[%0d]", k), 32'({d_m1_ready[k], d_m0_ready[k]}), 32'd0);
    end
    cycle();
    check_quiet("after_abort");
    // s_ready while idle is ignored.
    s_ready = 1'b1;
    s_rdata = 32'hFFFF_0001;
    #1;
    for (int k = 0; k < 2; k++)
      check($sformatf("idle_sready_ready[%0d]", k), 32'({d_m1_ready[k], d_m0_ready[k]}), 32'd0);
    cycle();
    s_ready = 1'b0;
    s_rdata = 32'h0;
    check_quiet("idle_sready");
    run_txn(mk(1, 1, 4'h0, 4'h0, 1, $urandom, 2'b10, 2'b01));

    // Reset in the middle of a BUSY transfer, then a normal m0 request.
    v = mk(1, 0, 4'h0, 4'h0, 0, $urandom, 2'b01, 2'b01);
    drive_vec(v);
    cycle();
    for (int k = 0; k < 2; k++) check($sformatf("pre_rst_gnt[%0d]", k), 32'(d_gnt[k]), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_quiet("mid_rst");
    run_txn(v);

`ifdef MEM_ARB_TIMEOUT_EN
    // Slave never answers: forced completion in the TMO-th BUSY cycle.
    v = mk(1, 0, 4'h0, 4'h0, 0, $urandom, 2'b01, 2'b01);
    drive_vec(v);
    cycle();
    for (int c = 1; c < TMO; c++) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("tmo_wait_ready[%0d]", k), 32'(d_m0_ready[k]), 32'd0);
        check($sformatf("tmo_wait_err[%0d]", k), 32'(d_err[k]), 32'd0);
      end
      cycle();
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("tmo_ready[%0d]", k), 32'(d_m0_ready[k]), 32'd1);
      check($sformatf("tmo_rdata[%0d]", k), d_m0_rdata[k], 32'hDEAD_BEEF);
      check($sformatf("tmo_err[%0d]", k), 32'(d_err[k]), 32'd1);
      check($sformatf("tmo_s_valid[%0d]", k), 32'(d_s_valid[k]), 32'd0);
    end
    m0_valid = 1'b0;
    cycle();
    check_quiet("after_tmo");
    // s_ready arriving in the expiry cycle wins; no err.
    drive_vec(v);
    repeat (TMO) cycle();
    s_ready = 1'b1;
    s_rdata = 32'h0BAD_F00D;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("tie_ready[%0d]", k), 32'(d_m0_ready[k]), 32'd1);
      check($sformatf("tie_rdata[%0d]", k), d_m0_rdata[k], 32'h0BAD_F00D);
      check($sformatf("tie_err[%0d]", k), 32'(d_err[k]), 32'd0);
    end
    cycle();
    s_ready = 1'b0;
    m0_valid = 1'b0;
    cycle();
    check_quiet("after_tie");
`else
    // No watchdog: a long stall is simply waited out.
    run_txn(mk(0, 1, 4'h0, 4'h5, 3 * TMO, $urandom, 2'b10, 2'b10));
`endif

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
